// File: rtl/hazard_ctrl_unit.sv
// Hazard and forwarding controller for the 5-stage LEGv8 pipeline.
// Enables, flushes, bubbles and forward selects are combinational; FSM and counters are registered.
module hazard_ctrl_unit #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rn,
  input  logic [4:0]       ifid_rm,
  input  logic             ifid_uses_rm,
  input  logic             ifid_is_bcond,
  input  logic [4:0]       idex_rn,
  input  logic [4:0]       idex_rm,
  input  logic [4:0]       idex_rd,
  input  logic             idex_regwrite,
  input  logic             idex_memtoreg,
  input  logic             idex_setflags,
  input  logic [4:0]       exmem_rd,
  input  logic             exmem_regwrite,
  input  logic [4:0]       memwr_rd,
  input  logic             memwr_regwrite,
  input  logic             branch_taken,
  input  logic             freeze,
  output logic             pc_enable,
  output logic             ifid_enable,
  output logic             idex_enable,
  output logic             exmem_enable,
  output logic             memwr_enable,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_FLUSH   = 1'b1;
  localparam logic [4:0] XZR        = 5'd31;
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [1:0] FWD_REG    = 2'b00;
  localparam logic [1:0] FWD_EXMEM  = 2'b10;
  localparam logic [1:0] FWD_MEMWR  = 2'b01;

  logic [0:0] state_r;
  logic [0:0] state_nxt_s;
  logic [1:0] fcnt_r;
  logic [1:0] fcnt_nxt_s;
  logic       load_use_s;
  logic       flag_haz_s;
  logic       stall_s;
  logic       branch_acc_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;

  // EX/MEM wins over MEM/WR so the youngest producer is forwarded; XZR never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] em_rd,
    input logic       em_rw,
    input logic [4:0] mw_rd,
    input logic       mw_rw
  );
    logic [1:0] sel;
    if (em_rw && (em_rd != XZR) && (em_rd == src)) begin
      sel = FWD_EXMEM;
    end else if (mw_rw && (mw_rd != XZR) && (mw_rd == src)) begin
      sel = FWD_MEMWR;
    end else begin
      sel = FWD_REG;
    end
    return sel;
  endfunction

  // Hazard detection and forwarding selects
  always_comb begin
    load_use_s = idex_memtoreg && idex_regwrite && (idex_rd != XZR) &&
                 ((idex_rd == ifid_rn) || (ifid_uses_rm && (idex_rd == ifid_rm)));
    flag_haz_s = ifid_is_bcond && idex_setflags;
    fwd_a_s    = fwd_sel(idex_rn, exmem_rd, exmem_regwrite, memwr_rd, memwr_regwrite);
    fwd_b_s    = fwd_sel(idex_rm, exmem_rd, exmem_regwrite, memwr_rd, memwr_regwrite);
  end

  // Stage control outputs and FSM next state; freeze > branch > flush-in-progress > stall
  always_comb begin
    pc_enable    = 1'b1;
    ifid_enable  = 1'b1;
    idex_enable  = 1'b1;
    exmem_enable = 1'b1;
    memwr_enable = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    forward_a    = FWD_REG;
    forward_b    = FWD_REG;
    stall_s      = 1'b0;
    branch_acc_s = 1'b0;
    state_nxt_s  = state_r;
    fcnt_nxt_s   = fcnt_r;
    if (!reset) begin
      state_nxt_s = ST_RUN;
      fcnt_nxt_s  = 2'd0;
    end else if (freeze) begin
      pc_enable    = 1'b0;
      ifid_enable  = 1'b0;
      idex_enable  = 1'b0;
      exmem_enable = 1'b0;
      memwr_enable = 1'b0;
      forward_a    = fwd_a_s;
      forward_b    = fwd_b_s;
    end else begin
      forward_a = fwd_a_s;
      forward_b = fwd_b_s;
      if (branch_taken) begin
        ifid_flush   = 1'b1;
        idex_bubble  = 1'b1;
        branch_acc_s = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_nxt_s = ST_FLUSH;
          fcnt_nxt_s  = FLUSH_LOAD;
        end else begin
          state_nxt_s = ST_RUN;
          fcnt_nxt_s  = 2'd0;
        end
      end else if (state_r == ST_FLUSH) begin
        ifid_flush = 1'b1;
        if (fcnt_r <= 2'd1) begin
          state_nxt_s = ST_RUN;
          fcnt_nxt_s  = 2'd0;
        end else begin
          fcnt_nxt_s = fcnt_r - 2'd1;
        end
      end else if (load_use_s || flag_haz_s) begin
        pc_enable   = 1'b0;
        ifid_enable = 1'b0;
        idex_bubble = 1'b1;
        stall_s     = 1'b1;
      end else begin
        state_nxt_s = ST_RUN;
      end
    end
  end

  // FSM state, flush down-counter and saturating event counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_RUN;
      fcnt_r    <= 2'd0;
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      fcnt_r  <= fcnt_nxt_s;
      if (stall_s && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (branch_acc_s && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed table-driven bench for hazard_ctrl_unit (FLUSH_CYCLES=2, CNT_W=2).
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ifid_rn, ifid_rm, idex_rn, idex_rm, idex_rd, exmem_rd, memwr_rd;
  logic       ifid_uses_rm, ifid_is_bcond, idex_regwrite, idex_memtoreg, idex_setflags;
  logic       exmem_regwrite, memwr_regwrite, branch_taken, freeze;
  logic       pc_enable, ifid_enable, idex_enable, exmem_enable, memwr_enable;
  logic       ifid_flush, idex_bubble;
  logic [1:0] forward_a, forward_b;
  logic [1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // {pc, ifid, idex, exmem, memwr, flush, bubble}
  localparam logic [6:0] C_RUN   = 7'b1111100;
  localparam logic [6:0] C_STALL = 7'b0011101;
  localparam logic [6:0] C_BR    = 7'b1111111;
  localparam logic [6:0] C_FLUSH = 7'b1111110;
  localparam logic [6:0] C_FRZ   = 7'b0000000;

  wire [6:0] ctrl = {pc_enable, ifid_enable, idex_enable, exmem_enable, memwr_enable,
                     ifid_flush, idex_bubble};
  wire [3:0] fwd  = {forward_a, forward_b};

  hazard_ctrl_unit #(.FLUSH_CYCLES(2), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .ifid_rn(ifid_rn), .ifid_rm(ifid_rm), .ifid_uses_rm(ifid_uses_rm), .ifid_is_bcond(ifid_is_bcond),
    .idex_rn(idex_rn), .idex_rm(idex_rm), .idex_rd(idex_rd),
    .idex_regwrite(idex_regwrite), .idex_memtoreg(idex_memtoreg), .idex_setflags(idex_setflags),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .memwr_rd(memwr_rd), .memwr_regwrite(memwr_regwrite),
    .branch_taken(branch_taken), .freeze(freeze),
    .pc_enable(pc_enable), .ifid_enable(ifid_enable), .idex_enable(idex_enable),
    .exmem_enable(exmem_enable), .memwr_enable(memwr_enable),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .forward_a(forward_a), .forward_b(forward_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] ifid_rn, ifid_rm;
    logic       uses_rm, is_bcond;
    logic [4:0] idex_rn, idex_rm, idex_rd;
    logic       idex_rw, idex_mtr, idex_sf;
    logic [4:0] em_rd;
    logic       em_rw;
    logic [4:0] mw_rd;
    logic       mw_rw;
    logic [3:0] exp_fwd;
    logic [6:0] exp_ctrl;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifid_rn = 5'd0; ifid_rm = 5'd0; ifid_uses_rm = 1'b0; ifid_is_bcond = 1'b0;
    idex_rn = 5'd0; idex_rm = 5'd0; idex_rd = 5'd0;
    idex_regwrite = 1'b0; idex_memtoreg = 1'b0; idex_setflags = 1'b0;
    exmem_rd = 5'd0; exmem_regwrite = 1'b0; memwr_rd = 5'd0; memwr_regwrite = 1'b0;
    branch_taken = 1'b0; freeze = 1'b0;
  endtask

  task automatic set_load_use();
    idex_memtoreg = 1'b1; idex_regwrite = 1'b1; idex_rd = 5'd5; ifid_rn = 5'd5;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    next();
    reset = 1'b1;
    next();
  endtask

  initial begin
    //        ifrn   ifrm   urm   bc    exrn   exrm   exrd   rw    mtr   sf    emrd   emrw  mwrd   mwrw  fwd      ctrl
    vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd3,  5'd3,  5'd0,  1'b0, 1'b0, 1'b0, 5'd3,  1'b1, 5'd3,  1'b1, 4'b1010, C_RUN};
    vecs[1]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd3,  5'd3,  5'd0,  1'b0, 1'b0, 1'b0, 5'd3,  1'b0, 5'd3,  1'b1, 4'b0101, C_RUN};
    vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd31, 5'd2,  5'd0,  1'b0, 1'b0, 1'b0, 5'd31, 1'b1, 5'd0,  1'b0, 4'b0000, C_RUN};
    vecs[3]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd31, 5'd31, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd31, 1'b1, 4'b0000, C_RUN};
    vecs[4]  = '{5'd31,5'd0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd31, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 4'b0000, C_RUN};
    vecs[5]  = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd5,  1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 4'b0000, C_STALL};
    vecs[6]  = '{5'd1, 5'd5, 1'b0, 1'b0, 5'd0,  5'd0,  5'd5,  1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 4'b0000, C_RUN};
    vecs[7]  = '{5'd1, 5'd5, 1'b1, 1'b0, 5'd0,  5'd0,  5'd5,  1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 4'b0000, C_STALL};
    vecs[8]  = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 4'b0000, C_RUN};
    vecs[9]  = '{5'd1, 5'd2, 1'b0, 1'b1, 5'd0,  5'd0,  5'd9,  1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 4'b0000, C_STALL};
    vecs[10] = '{5'd1, 5'd2, 1'b0, 1'b1, 5'd0,  5'd0,  5'd9,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 4'b0000, C_RUN};
    vecs[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd7,  5'd4,  5'd0,  1'b0, 1'b0, 1'b0, 5'd4,  1'b1, 5'd7,  1'b1, 4'b0110, C_RUN};
    vecs[12] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd4,  5'd9,  5'd0,  1'b0, 1'b0, 1'b0, 5'd4,  1'b0, 5'd4,  1'b1, 4'b0100, C_RUN};

    // Reset: outputs forced to defaults even with a forwarding match present
    clear_inputs();
    reset = 1'b0;
    exmem_rd = 5'd3; exmem_regwrite = 1'b1; idex_rn = 5'd3; idex_rm = 5'd3;
    next();
    @(negedge clk);
    check("reset_ctrl", 32'(ctrl), 32'(C_RUN));
    check("reset_fwd", 32'(fwd), 32'd0);
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset_flush_cnt", 32'(flush_cnt), 32'd0);
    reset = 1'b1;
    clear_inputs();
    next();

    for (int i = 0; i < 13; i++) begin
      ifid_rn = vecs[i].ifid_rn; ifid_rm = vecs[i].ifid_rm;
      ifid_uses_rm = vecs[i].uses_rm; ifid_is_bcond = vecs[i].is_bcond;
      idex_rn = vecs[i].idex_rn; idex_rm = vecs[i].idex_rm; idex_rd = vecs[i].idex_rd;
      idex_regwrite = vecs[i].idex_rw; idex_memtoreg = vecs[i].idex_mtr;
      idex_setflags = vecs[i].idex_sf;
      exmem_rd = vecs[i].em_rd; exmem_regwrite = vecs[i].em_rw;
      memwr_rd = vecs[i].mw_rd; memwr_regwrite = vecs[i].mw_rw;
      @(negedge clk);
      check($sformatf("vec%0d_fwd", i), 32'(fwd), 32'(vecs[i].exp_fwd));
      check($sformatf("vec%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].exp_ctrl));
      next();
    end

    clear_inputs();
    do_reset();
    check("rst2_stall_cnt", 32'(stall_cnt), 32'd0);

    // Load-use: one stall cycle, then bubble in ID/EX clears it
    set_load_use();
    @(negedge clk);
    check("lu_stall", 32'(ctrl), 32'(C_STALL));
    next();
    clear_inputs();
    @(negedge clk);
    check("lu_after", 32'(ctrl), 32'(C_RUN));
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // Branch with two flush cycles; hazard in FLUSH is suppressed
    next();
    branch_taken = 1'b1;
    @(negedge clk);
    check("br_cycle1", 32'(ctrl), 32'(C_BR));
    next();
    branch_taken = 1'b0;
    set_load_use();
    @(negedge clk);
    check("br_cycle2", 32'(ctrl), 32'(C_FLUSH));
    check("br_flush_cnt", 32'(flush_cnt), 32'd1);
    check("br_stall_cnt", 32'(stall_cnt), 32'd1);
    next();
    @(negedge clk);
    check("br_back_run", 32'(ctrl), 32'(C_STALL));
    next();
    clear_inputs();
    @(negedge clk);
    check("br_stall_cnt2", 32'(stall_cnt), 32'd2);

    // Load-use together with branch: branch wins
    next();
    set_load_use();
    branch_taken = 1'b1;
    @(negedge clk);
    check("sim_lu_br", 32'(ctrl), 32'(C_BR));
    next();
    clear_inputs();
    @(negedge clk);
    check("sim_stall_cnt", 32'(stall_cnt), 32'd2);
    check("sim_flush_cnt", 32'(flush_cnt), 32'd2);
    check("sim_flush2", 32'(ctrl), 32'(C_FLUSH));
    next();
    @(negedge clk);
    check("sim_run", 32'(ctrl), 32'(C_RUN));

    // Freeze with branch: nothing accepted
    next();
    freeze = 1'b1;
    branch_taken = 1'b1;
    @(negedge clk);
    check("frz_br", 32'(ctrl), 32'(C_FRZ));
    next();
    clear_inputs();
    @(negedge clk);
    check("frz_flush_cnt", 32'(flush_cnt), 32'd2);
    check("frz_run", 32'(ctrl), 32'(C_RUN));

    // Freeze during FLUSH holds the remaining flush cycle
    next();
    branch_taken = 1'b1;
    @(negedge clk);
    check("frzf_br", 32'(ctrl), 32'(C_BR));
    next();
    branch_taken = 1'b0;
    freeze = 1'b1;
    @(negedge clk);
    check("frzf_hold", 32'(ctrl), 32'(C_FRZ));
    check("frzf_flush_cnt", 32'(flush_cnt), 32'd3);
    next();
    freeze = 1'b0;
    @(negedge clk);
    check("frzf_resume", 32'(ctrl), 32'(C_FLUSH));
    next();
    @(negedge clk);
    check("frzf_run", 32'(ctrl), 32'(C_RUN));

    // Reset asserted mid-FLUSH
    next();
    branch_taken = 1'b1;
    next();
    branch_taken = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("rstf_ctrl_low", 32'(ctrl), 32'(C_RUN));
    next();
    reset = 1'b1;
    @(negedge clk);
    check("rstf_ctrl", 32'(ctrl), 32'(C_RUN));
    check("rstf_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rstf_flush_cnt", 32'(flush_cnt), 32'd0);

    // Saturation: continuous hazard, counter stops at 3
    next();
    set_load_use();
    @(negedge clk);
    check("sat_stall", 32'(ctrl), 32'(C_STALL));
    for (int k = 1; k <= 5; k++) begin
      next();
      @(negedge clk);
      check($sformatf("sat_cnt%0d", k), 32'(stall_cnt), (k < 3) ? 32'(k) : 32'd3);
    end
    clear_inputs();
    next();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
